inv_cipher: RTL and testbench
=============================

# inv_cipher

AES-128 inverse cipher core: the decrypt-direction counterpart of the `cipher` encrypt block. It consumes a 128-bit ciphertext and produces the plaintext. It reads the pre-expanded round keys from the shared `key_sram` in descending order, round 10 down to round 0. It sits beside `cipher` under the AES top level and shares the SRAM read port (`round_no`/`r_e`) through the top-level address mux.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds. Only 10 (AES-128) is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  start strobe, sampled on a rising edge while idle
- `ciphertext`  in  `BLK_S`  input block, captured on the start edge
- `key`  in  `KEY_S`  round key from the `key_sram` `o_data` output
- `round_no`  out  `Nk`  SRAM address of the round key being requested
- `r_e`  out  1  SRAM read enable
- `plaintext`  out  `BLK_S`  result block; held until the next completion
- `en_o`  out  1  one-cycle done pulse
- `busy`  out  1  present only with `INV_CIPHER_BUSY_EN`

## Operation
- Byte and word order is MSB-first (`[0:127]`), identical to `cipher`. Byte 0 is `ciphertext[0:7]`, and the state is column-major.
- FSM states:
  - IDLE: on `en`=1, capture the ciphertext, load the counter with 10 and set `r_e`=1. Go to FETCH.
  - FETCH: wait one cycle for the SRAM output. Decrement the counter to 9. Go to INIT.
  - INIT: state ← ciphertext ^ k10. Decrement the counter. Go to ROUND.
  - ROUND: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k[r]), for r = 9 down to 1. Move to FINAL after r=1 has been applied.
  - FINAL: plaintext ← InvSubBytes(InvShiftRows(state)) ^ k0. Set `en_o`=1 and `r_e`=0. Go to IDLE.
- `round_no` always equals the internal key counter. The counter runs one address ahead of its use, which covers the one-cycle SRAM read latency.
- The counter never decrements below 0. In FINAL and IDLE it holds 0.
- `en` is ignored in every state other than IDLE. There is no queueing.
- `en` and `en_o` may be high in the same cycle. In that case a new operation starts on that edge, so back-to-back operations take 13 cycles each.
- Round keys are never regenerated here. Key expansion and the SRAM write phase are complete before the first `en`, and this is the top level's responsibility.

## Timing
- Reset values: `plaintext` = 0, `en_o` = 0, `r_e` = 0, `round_no` = 0, `busy` = 0, FSM = IDLE, internal state = 0.
- `en` is sampled high at edge E0:
  - After E0: `round_no`=10, `r_e`=1.
  - Edge E2 applies k10.
  - Edges E3–E11 apply k9–k1.
  - Edge E12 applies k0 and registers the plaintext.
- `en_o` is high for exactly the one cycle after E12, with `plaintext` valid in the same cycle. Latency is 12 cycles from the sampling edge.
- `r_e` is high from after E0 through to edge E12.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately. No `en_o` is produced, and the next `en` starts cleanly.
- All outputs are registered. No combinational path runs from an input to an output.

## Configuration
- Macro `INV_CIPHER_BUSY_EN`:
  - Defined: the `busy` port exists. It is high from after E0 until the edge that asserts `en_o`, and is therefore low in the `en_o` cycle. The top level uses it to block key-SRAM writes and encrypt-side reads.
  - Undefined: the port is absent. Behaviour is otherwise identical.

## Structure
- Shared package `aes.vh` holds:
  - the existing constants `BLK_S`, `KEY_S` and `Nk`;
  - a new constant `Nr` = 10;
  - the InvShiftRows byte-permutation helper function;
  - the GF(2^8) `xtime` helper function.
- One sub-module, `inv_sbox`: a combinational 8-bit inverse S-box lookup, instantiated 16 times.
- InvMixColumns is a function within `inv_cipher`, implemented with multipliers 0e/0b/0d/09 built from `xtime`.

## Test plan
- FIPS-197 C.1: SRAM loaded from key 000102…0f, `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a → `plaintext`=00112233445566778899aabbccddeeff. `en_o` is high exactly 12 cycles after the `en` edge.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, `ciphertext`=3925841d02dc09fbdc118597196a0b32 → `plaintext`=3243f6a8885a308d313198a2e0370734. `round_no` sequence 10,9,…,0 is observed while `r_e`=1.
- `en` pulsed again at E5 of a C.1 run → ignored. A single `en_o` appears with the C.1 result.
- `en` held high continuously with vectors C.1 then B → two results 13 cycles apart, both correct.
- `reset` asserted at E7 → `en_o`, `r_e`, `round_no` and `plaintext` all go to 0 at once. A subsequent C.1 run passes.
- With `INV_CIPHER_BUSY_EN` defined: `busy` is high from after E0 until E12 and low in the `en_o` cycle. Without the macro the bench builds without the port.

Source files
------------

// File: rtl/inv_cipher_pkg.sv
// Shared AES constants, FSM state type and byte-level helpers for the
// inverse cipher. Byte order is MSB-first: byte 0 is bits [0:7].
package inv_cipher_pkg;

  localparam int BLK_S = 128;
  localparam int KEY_S = 128;
  localparam int Nk    = 4;
  localparam int Nr    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_INIT,
    ST_ROUND,
    ST_FINAL
  } inv_state_t;

  // Column-major state, byte index 4*c + r; row r rotates right by r.
  function automatic logic [0:BLK_S-1] inv_shift_rows(input logic [0:BLK_S-1] s);
    logic [0:BLK_S-1] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_cipher_sbox.sv
// Combinational AES inverse S-box lookup, one byte.
module inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Table lookup.
  always_comb y = INV_SBOX[x];

endmodule

// File: rtl/inv_cipher.sv
// AES-128 inverse cipher. Round keys are fetched from the shared key SRAM,
// round 10 down to 0, one address ahead of use to hide the read latency.
// Optional macro INV_CIPHER_BUSY_EN adds the busy output port.
//
// state | meaning
// IDLE  | waiting for en; captures ciphertext and requests k10
// FETCH | SRAM latency cycle, k10 arriving
// INIT  | state ^= k10
// ROUND | inverse rounds 9..1 (leaves when the key counter reaches 0)
// FINAL | last round with k0, registers plaintext and pulses en_o
module inv_cipher
  import inv_cipher_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [0:BLK_S-1] ciphertext,
  input  logic [0:KEY_S-1] key,
  output logic [Nk-1:0]    round_no,
  output logic             r_e,
  output logic [0:BLK_S-1] plaintext,
  output logic             en_o
`ifdef INV_CIPHER_BUSY_EN
  , output logic           busy
`endif
);

  inv_state_t       state, state_nxt;
  logic [0:BLK_S-1] blk, blk_nxt;
  logic [0:BLK_S-1] pt_nxt;
  logic [Nk-1:0]    cnt_nxt, cnt_dec;
  logic             r_e_nxt, en_o_nxt;
  logic [0:BLK_S-1] isr, isb;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{m[0]}} & a) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
  endfunction

  function automatic logic [0:BLK_S-1] inv_mix_columns(input logic [0:BLK_S-1] s);
    logic [0:BLK_S-1] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c    +: 8];
      a1 = s[32*c+8  +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[32*c+8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[32*c+16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[32*c+24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  assign isr = inv_shift_rows(blk);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .x (isr[8*i +: 8]),
      .y (isb[8*i +: 8])
    );
  end

  // Key counter saturates at zero; ROUND exits on that terminal count.
  assign cnt_dec = (round_no == '0) ? '0 : round_no - 1'b1;

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt = state;
    blk_nxt   = blk;
    pt_nxt    = plaintext;
    cnt_nxt   = round_no;
    r_e_nxt   = r_e;
    en_o_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          blk_nxt   = ciphertext;
          cnt_nxt   = Nk'(NR);
          r_e_nxt   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cnt_nxt   = cnt_dec;
        state_nxt = ST_INIT;
      end
      ST_INIT: begin
        blk_nxt   = blk ^ key;
        cnt_nxt   = cnt_dec;
        state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        blk_nxt = inv_mix_columns(isb ^ key);
        cnt_nxt = cnt_dec;
        if (round_no == '0) state_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        pt_nxt    = isb ^ key;
        en_o_nxt  = 1'b1;
        r_e_nxt   = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      blk       <= '0;
      plaintext <= '0;
      round_no  <= '0;
      r_e       <= 1'b0;
      en_o      <= 1'b0;
    end else begin
      state     <= state_nxt;
      blk       <= blk_nxt;
      plaintext <= pt_nxt;
      round_no  <= cnt_nxt;
      r_e       <= r_e_nxt;
      en_o      <= en_o_nxt;
    end
  end

`ifdef INV_CIPHER_BUSY_EN
  // Busy spans start edge to the edge that raises en_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          busy <= 1'b0;
    else if (state == ST_IDLE && en)    busy <= 1'b1;
    else if (state == ST_FINAL)         busy <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_inv_cipher.sv
// Scoreboard bench for inv_cipher using FIPS-197 vectors.
module tb_inv_cipher;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [0:127] ciphertext;
  logic [0:127] key;
  logic [3:0]   round_no;
  logic         r_e;
  logic [0:127] plaintext;
  logic         en_o;
`ifdef INV_CIPHER_BUSY_EN
  logic         busy;
`endif

  inv_cipher #(.NR(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ciphertext (ciphertext),
    .key        (key),
    .round_no   (round_no),
    .r_e        (r_e),
    .plaintext  (plaintext),
    .en_o       (en_o)
`ifdef INV_CIPHER_BUSY_EN
    , .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [0:127] rk_c1 [0:15];
  logic [0:127] rk_b  [0:15];
  bit           kset;

  typedef struct {
    logic [0:127] pt;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_en_o = 0;
  int n_expected = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Key SRAM model with one-cycle read latency.
  always @(posedge clk) if (r_e) key <= kset ? rk_b[round_no] : rk_c1[round_no];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    if (!reset && en_o) begin
      exp_t e;
      n_en_o++;
`ifdef INV_CIPHER_BUSY_EN
      check("busy_low_in_done", 128'(busy), 128'(0));
`endif
      if (sb.size() == 0) begin
        check("unexpected_en_o", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        check("plaintext", plaintext, e.pt);
        check("done_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the start edge E0.
  task automatic issue(input logic [0:127] ct, input bit ks, input logic [0:127] exp);
    exp_t e;
    ciphertext = ct;
    kset       = ks;
    en         = 1'b1;
    e.pt  = exp;
    e.cyc = cyc + 13;
    sb.push_back(e);
    n_expected++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rk_c1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_c1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_c1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_c1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_c1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_c1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_c1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_c1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_c1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_c1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_c1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rk_b[0]   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_b[1]   = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_b[2]   = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_b[3]   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_b[4]   = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_b[5]   = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_b[6]   = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_b[7]   = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_b[8]   = 128'head27321b58dbad2312bf5607f8d292f;
    rk_b[9]   = 128'hac7766f319fadc2128d12941575c006e;
    rk_b[10]  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 11; i < 16; i++) begin
      rk_c1[i] = '0;
      rk_b[i]  = '0;
    end

    reset = 1'b1; en = 1'b0; ciphertext = '0; kset = 1'b0;
    wait_neg(3);
    check("rst_plaintext", plaintext, 128'(0));
    check("rst_en_o", 128'(en_o), 128'(0));
    check("rst_r_e", 128'(r_e), 128'(0));
    check("rst_round_no", 128'(round_no), 128'(0));
`ifdef INV_CIPHER_BUSY_EN
    check("rst_busy", 128'(busy), 128'(0));
`endif
    reset = 1'b0;
    wait_neg(2);

    // FIPS-197 C.1
    issue(CT_C1, 1'b0, PT_C1);
    en = 1'b0;
    drain();
    wait_neg(2);

    // FIPS-197 B with round_no / r_e sequence
    issue(CT_B, 1'b1, PT_B);
    en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("round_no_E%0d", k), 128'(round_no), 128'((10 - k) < 0 ? 0 : (10 - k)));
      check($sformatf("r_e_E%0d", k), 128'(r_e), 128'(1));
`ifdef INV_CIPHER_BUSY_EN
      check($sformatf("busy_E%0d", k), 128'(busy), 128'(1));
`endif
      @(negedge clk);
    end
    check("r_e_after_E12", 128'(r_e), 128'(0));
    check("round_no_after_E12", 128'(round_no), 128'(0));
    drain();
    wait_neg(2);

    // en re-pulsed at E5 is ignored
    issue(CT_C1, 1'b0, PT_C1);
    en = 1'b0;
    wait_neg(4);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drain();
    wait_neg(20);

    // en held high: C.1 then B back to back, 13 cycles apart
    issue(CT_C1, 1'b0, PT_C1);
    wait_neg(12);
    issue(CT_B, 1'b1, PT_B);
    en = 1'b0;
    drain();
    wait_neg(3);

    // reset asserted just after E7 of a C.1 run
    issue(CT_C1, 1'b0, PT_C1);
    en = 1'b0;
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_en_o", 128'(en_o), 128'(0));
    check("midrst_r_e", 128'(r_e), 128'(0));
    check("midrst_round_no", 128'(round_no), 128'(0));
    check("midrst_plaintext", plaintext, 128'(0));
`ifdef INV_CIPHER_BUSY_EN
    check("midrst_busy", 128'(busy), 128'(0));
`endif
    sb.delete();
    n_expected--;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(2);
    issue(CT_C1, 1'b0, PT_C1);
    en = 1'b0;
    drain();
    wait_neg(20);

    check("en_o_count", 128'(n_en_o), 128'(n_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
